// File: rtl/tick_counter_pkg.sv
// Shared definitions for the tick-driven BCD counter: FSM encoding and
// per-digit BCD constants.
package tick_counter_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the counter with up/down stepping and a ripple carry.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clr           : synchronous clear to 0
//   en            : step request (tick for digit 0, lower carry otherwise)
//   dir           : 1 = count up, 0 = count down
//   carry_in      : qualifies en; the digit only steps when both are high
//   digit         : registered digit value, always 0..9
//   carry_out     : combinational; high when this step wraps the digit
module bcd_digit
  import tick_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  input  logic             carry_in,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  logic [BCD_W-1:0] r_digit;
  logic [BCD_W-1:0] w_digit_nxt;
  logic             w_step;
  logic             w_at_limit;

  assign w_step     = en & carry_in;
  // >= keeps the up path safe even if a corrupt value ever appeared
  assign w_at_limit = dir ? (r_digit >= BCD_MAX) : (r_digit == BCD_MIN);
  assign carry_out  = w_step & w_at_limit;
  assign digit      = r_digit;

  // Next digit value: wrap 9->0 going up, 0->9 going down
  always_comb begin
    w_digit_nxt = r_digit;
    if (w_step) begin
      if (dir) begin
        w_digit_nxt = w_at_limit ? BCD_MIN : BCD_W'(r_digit + BCD_W'(1));
      end else begin
        w_digit_nxt = w_at_limit ? BCD_MAX : BCD_W'(r_digit - BCD_W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_digit <= BCD_MIN;
    end else begin
      r_digit <= w_digit_nxt;
    end
  end

endmodule

// File: rtl/tick_bcd_counter.sv
// Multi-digit BCD up/down counter advanced by divider ticks, with run/pause
// and clear controlled by rising edges of debounced buttons.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   tick      : one-cycle count-enable pulse
//   run_btn   : rising edge toggles run/pause (starts from idle)
//   clr_btn   : rising edge clears the count and returns to idle
//   dir       : 1 = up, 0 = down, sampled on counted ticks
//   bcd       : registered count, digit 0 in bits [3:0]
//   wrap      : one-cycle pulse when the count wraps around
//   running   : registered, high while in RUN
module tick_bcd_counter
  import tick_counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic                        run_btn,
  input  logic                        clr_btn,
  input  logic                        dir,
  output logic [BCD_W*NUM_DIGITS-1:0] bcd,
  output logic                        wrap,
  output logic                        running
);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_run_q;
  logic   r_clr_q;
  logic   r_wrap;
  logic   r_running;
  logic   w_run_edge;
  logic   w_clr_edge;
  logic   w_count_en;
  logic [NUM_DIGITS-1:0] w_carry;

  assign w_run_edge = run_btn & ~r_run_q;
  assign w_clr_edge = clr_btn & ~r_clr_q;
  // A clear in the same cycle wins over the tick, so the tick is dropped
  assign w_count_en = tick & (r_state == RUN) & ~w_clr_edge;

  assign wrap    = r_wrap;
  assign running = r_running;

  // Next-state: clear has priority, otherwise a run edge toggles
  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_edge) begin
      w_state_nxt = IDLE;
    end else if (w_run_edge) begin
      case (r_state)
        IDLE:    w_state_nxt = RUN;
        RUN:     w_state_nxt = PAUSE;
        PAUSE:   w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, edge-detect history, and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_run_q   <= 1'b0;
      r_clr_q   <= 1'b0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_q   <= run_btn;
      r_clr_q   <= clr_btn;
      // Top digit carries only when every digit was at its limit
      r_wrap    <= w_carry[NUM_DIGITS-1];
      r_running <= (w_state_nxt == RUN);
    end
  end

  // Digit chain: each digit steps on the carry out of the one below it
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic w_en;
    if (k == 0) begin : g_lsd
      assign w_en = w_count_en;
    end else begin : g_upper
      assign w_en = w_carry[k-1];
    end

    bcd_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .clr       (w_clr_edge),
      .en        (w_en),
      .dir       (dir),
      .carry_in  (w_count_en),
      .digit     (bcd[k*BCD_W +: BCD_W]),
      .carry_out (w_carry[k])
    );
  end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed bench for tick_bcd_counter with a reference model feeding an
// expected-value queue that is drained one entry per clock.
module tb_tick_bcd_counter;

  localparam int unsigned ND    = 4;
  localparam int          MAXV  = 9999;

  logic            clk;
  logic            rst;
  logic            tick;
  logic            run_btn;
  logic            clr_btn;
  logic            dir;
  logic [4*ND-1:0] bcd;
  logic            wrap;
  logic            running;

  tick_bcd_counter #(.NUM_DIGITS(ND)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .run_btn (run_btn),
    .clr_btn (clr_btn),
    .dir     (dir),
    .bcd     (bcd),
    .wrap    (wrap),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*ND-1:0] bcd;
    logic            wrap;
    logic            running;
  } exp_t;

  exp_t q[$];

  int total;
  int bad;
  bit wrap_seen;

  // Reference model: plain integer count and state number
  int m_cnt;
  int m_state;   // 0 idle, 1 run, 2 pause
  bit m_run_q;
  bit m_clr_q;
  bit m_wrap;

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < int'(ND); i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_step();
    bit re;
    bit ce;
    if (rst) begin
      m_cnt = 0; m_state = 0; m_wrap = 0; m_run_q = 0; m_clr_q = 0;
    end else begin
      re = run_btn && !m_run_q;
      ce = clr_btn && !m_clr_q;
      m_wrap = 0;
      if (ce) begin
        m_state = 0;
        m_cnt   = 0;
      end else begin
        if (m_state == 1 && tick) begin
          if (dir) begin
            if (m_cnt == MAXV) begin m_cnt = 0; m_wrap = 1; end
            else m_cnt = m_cnt + 1;
          end else begin
            if (m_cnt == 0) begin m_cnt = MAXV; m_wrap = 1; end
            else m_cnt = m_cnt - 1;
          end
        end
        if (re) m_state = (m_state == 1) ? 2 : 1;
      end
      m_run_q = run_btn;
      m_clr_q = clr_btn;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the model's expectation, compare after edge
  task automatic cyc(input logic t, input logic d);
    exp_t e;
    tick = t;
    dir  = d;
    model_step();
    e.bcd     = to_bcd(m_cnt);
    e.wrap    = m_wrap;
    e.running = (m_state == 1);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("sb_bcd",     32'(bcd),     32'(e.bcd));
    check("sb_wrap",    32'(wrap),    32'(e.wrap));
    check("sb_running", 32'(running), 32'(e.running));
    if (wrap) wrap_seen = 1'b1;
    tick = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; wrap_seen = 1'b0;
    m_cnt = 0; m_state = 0; m_run_q = 0; m_clr_q = 0; m_wrap = 0;
    rst = 1'b1; tick = 1'b0; run_btn = 1'b0; clr_btn = 1'b0; dir = 1'b1;

    // Reset
    cyc(0, 1);
    cyc(0, 1);
    check("rst_bcd",     32'(bcd),     32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_wrap",    32'(wrap),    32'h0);
    rst = 1'b0;
    cyc(0, 1);

    // Start and count 12 up
    run_btn = 1'b1; cyc(0, 1); run_btn = 1'b0;
    wrap_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1);
      cyc(0, 1);
    end
    check("up12_bcd",     32'(bcd),       32'h0012);
    check("up12_running", 32'(running),   32'h1);
    check("up12_nowrap",  32'(wrap_seen), 32'h0);

    // Preload to 9998, then roll over to 0000
    for (int i = 0; i < 9986; i++) cyc(1, 1);
    check("pre_9998", 32'(bcd), 32'h9998);
    cyc(1, 1);
    check("up_9999",      32'(bcd),  32'h9999);
    check("up_9999_wrap", 32'(wrap), 32'h0);
    cyc(1, 1);
    check("up_0000",      32'(bcd),  32'h0000);
    check("up_0000_wrap", 32'(wrap), 32'h1);
    cyc(0, 1);
    check("up_wrap_1cyc", 32'(wrap), 32'h0);

    // Down through zero
    cyc(1, 0);
    check("dn_9999",      32'(bcd),  32'h9999);
    check("dn_9999_wrap", 32'(wrap), 32'h1);
    cyc(0, 0);
    check("dn_wrap_1cyc", 32'(wrap), 32'h0);
    cyc(1, 0);
    check("dn_9998",      32'(bcd),  32'h9998);

    // Up to 0042, then run edge together with a tick
    for (int i = 0; i < 44; i++) cyc(1, 1);
    check("at_0042", 32'(bcd), 32'h0042);
    run_btn = 1'b1; cyc(1, 1); run_btn = 1'b0;
    check("pause_bcd",     32'(bcd),     32'h0043);
    check("pause_running", 32'(running), 32'h0);
    for (int i = 0; i < 5; i++) cyc(1, 1);
    check("pause_hold", 32'(bcd), 32'h0043);

    // Resume, count to 0107, then clear + run + tick together
    run_btn = 1'b1; cyc(0, 1); run_btn = 1'b0;
    check("resume_running", 32'(running), 32'h1);
    for (int i = 0; i < 64; i++) cyc(1, 1);
    check("at_0107", 32'(bcd), 32'h0107);
    clr_btn = 1'b1; run_btn = 1'b1;
    cyc(1, 1);
    check("clr_bcd",     32'(bcd),     32'h0000);
    check("clr_running", 32'(running), 32'h0);
    check("clr_wrap",    32'(wrap),    32'h0);
    cyc(1, 1);
    check("clr_held_idle", 32'(bcd), 32'h0000);
    clr_btn = 1'b0; run_btn = 1'b0;
    cyc(0, 1);

    // Count to 0505, reset mid-count with run_btn held through release
    run_btn = 1'b1; cyc(0, 1); run_btn = 1'b0;
    for (int i = 0; i < 505; i++) cyc(1, 1);
    check("at_0505", 32'(bcd), 32'h0505);
    run_btn = 1'b1;
    rst = 1'b1;
    cyc(1, 1);
    check("mid_rst_bcd",     32'(bcd),     32'h0000);
    check("mid_rst_wrap",    32'(wrap),    32'h0);
    check("mid_rst_running", 32'(running), 32'h0);
    rst = 1'b0;
    cyc(0, 1);
    cyc(0, 1);
    check("post_rst_running", 32'(running), 32'h1);
    check("post_rst_bcd",     32'(bcd),     32'h0000);
    cyc(1, 1);
    check("post_rst_count", 32'(bcd), 32'h0001);
    run_btn = 1'b0;
    cyc(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_bcd_counter.md
TICK_BCD_COUNTER -- requirements
Module: tick_bcd_counter

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of BCD digits (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; every register is clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port tick, input, 1 bit: count-enable pulse, one clk cycle wide, from the upstream clock divider.
REQ-005 The block SHALL have port run_btn, input, 1 bit: debounced level; each rising edge toggles run/pause.
REQ-006 The block SHALL have port clr_btn, input, 1 bit: debounced level; each rising edge clears the count and stops counting.
REQ-007 The block SHALL have port dir, input, 1 bit: count direction, 1 = up, 0 = down; sampled only on counted ticks.
REQ-008 The block SHALL have port bcd, output, 4*NUM_DIGITS bits: registered count; digit 0 is bits [3:0] and is least significant.
REQ-009 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on wrap-around.
REQ-010 The block SHALL have port running, output, 1 bit: high while in state RUN.

Function
REQ-011 The block SHALL detect rising edges of run_btn and clr_btn by comparing each with its own value registered one clk earlier.
- Only edges act; a held level has no further effect.
REQ-012 The block SHALL implement three states:
- IDLE: count zero, not counting.
- RUN: counting.
- PAUSE: count held.
REQ-013 State transitions SHALL be as follows:
- IDLE to RUN on a run edge.
- RUN to PAUSE on a run edge.
- PAUSE to RUN on a run edge.
- Any state to IDLE on a clr edge.
REQ-014 A clr edge SHALL take priority over a run edge and a tick in the same cycle: the state goes to IDLE, bcd goes to all zeros, and wrap stays low.
REQ-015 In RUN, a tick SHALL update bcd on the next clk edge (1-cycle latency); bcd SHALL be unchanged in every other cycle.
REQ-016 Up count SHALL be decimal per digit: a digit at 9 goes to 0 and carries into the next digit; the carry SHALL ripple through all digits within the same cycle.
REQ-017 Down count SHALL be decimal per digit: a digit at 0 goes to 9 and borrows from the next digit.
REQ-018 Counting up from all-nines SHALL give all zeros, and wrap SHALL be high for exactly the cycle in which bcd first shows all zeros.
REQ-019 Counting down from all zeros SHALL give all nines, and wrap SHALL be high for exactly the cycle in which bcd first shows all nines.
REQ-020 Ticks in IDLE or PAUSE SHALL be ignored, and they SHALL NOT be queued.
REQ-021 A run edge and a tick in the same cycle SHALL be handled by the state before the edge:
- In RUN, the tick is counted, then the state goes to PAUSE.
- In PAUSE, the tick is ignored, then the state goes to RUN.
REQ-022 A change on dir between ticks SHALL take effect on the next counted tick, with no glitch or skipped value.
REQ-023 Each digit SHALL only ever hold a value 0..9; a non-BCD value SHALL never appear on bcd.
REQ-024 The running output SHALL be registered and equal 1 exactly when the state is RUN.

Reset
REQ-025 When rst is high at a clk edge, the block SHALL clear the state to IDLE, bcd to all zeros, wrap to 0, running to 0, and both edge-detect registers to 0.
REQ-026 Reset SHALL override all inputs in the same cycle; a reset in the middle of a count SHALL discard the count with no wrap pulse.
REQ-027 When rst is released, a run_btn already held high SHALL produce one rising edge and start counting.

Structure
REQ-028 A shared package tick_counter_pkg SHALL hold:
- the state encoding (IDLE, RUN, PAUSE);
- the constant BCD_W = 4;
- the constants BCD_MAX = 9 and BCD_MIN = 0.
REQ-029 Each digit SHALL be an instance of sub-module bcd_digit, generated NUM_DIGITS times.
- Inputs: clk, rst, clr, en, dir, carry_in.
- Outputs: digit, carry_out.
- Digit 0 takes en = tick & RUN; digit k takes en = carry_out of digit k-1.

Verification
REQ-030 The bench SHALL run: reset, run edge, 12 ticks with dir=1 -> bcd = 0x0012, running = 1, wrap never high.
REQ-031 The bench SHALL run: preload to 9998 by ticking, then 2 ticks with dir=1 -> 9999 then 0000, with wrap high for exactly 1 cycle at 0000.
REQ-032 The bench SHALL run: from 0000 in RUN, 1 tick with dir=0 -> bcd = 0x9999 and wrap pulses once; a further tick gives 0x9998.
REQ-033 The bench SHALL run: at 0x0042 in RUN, a run edge and a tick in the same cycle -> bcd = 0x0043 and state PAUSE; 5 more ticks -> bcd still 0x0043.
REQ-034 The bench SHALL run: at 0x0107, clr edge, run edge and tick all in one cycle -> bcd = 0x0000, state IDLE, running = 0, no wrap.
REQ-035 The bench SHALL run: rst asserted for 1 cycle at 0x0505 in RUN, with run_btn held high through release -> bcd = 0x0000, then running = 1 two cycles after release.
